// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared RV32I load/store funct3 codes and responder FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Load access codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store access codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // True when funct3 names a real access of the requested direction.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder_if
//  Purpose  : Request/response handshake bundle between core and data memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmem_sram.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_sram
//  Purpose  : Single-port synchronous word array with byte enables. Contents
//             are deliberately not reset.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_sram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // One access per enabled cycle: byte-masked write, or registered read.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : RV32I data-memory slave. Latches one load/store, performs a
//             single array access, then holds the response until consumed.
//             Faulting requests never touch the array and return zero data.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic            clk,
  input  logic            reset_n,
  dmem_responder_if.slave bus
);

  localparam int c_aw = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_req_ready;
  logic        w_rsp_valid;
  logic        w_mem_en;
  logic        w_misaligned;
  logic        w_range_err;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_sram_rdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  // State register; reset aborts any in-flight access or response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Capture the request only in the IDLE accepting cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
    end else if (r_state == ST_IDLE && bus.req_valid) begin
      r_we     <= bus.req_we;
      r_funct3 <= bus.req_funct3;
      r_addr   <= bus.req_addr;
      r_wdata  <= bus.req_wdata;
    end
  end

  // Next-state and handshake outputs; the array is touched only in ACCESS.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_mem_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_mem_en    = ~w_err;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Fault detection: size code, natural alignment and word range.
  always_comb begin
    case (r_funct3[1:0])
      2'b01:   w_misaligned = r_addr[0];
      2'b10:   w_misaligned = (r_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
    w_range_err = ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));
    w_err       = ~f3_legal(r_we, r_funct3) | w_misaligned | w_range_err;
  end

  // Store lane enables and data replicated across lanes.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = r_wdata;
    case (r_funct3)
      F3_SB: begin
        w_be    = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      F3_SH: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      F3_SW: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (c_aw)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_mem_en),
    .i_we    (r_we),
    .i_be    (w_be),
    .i_addr  (r_addr[c_aw+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_sram_rdata)
  );

  // Load lane selection and sign/zero extension.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = w_sram_rdata[7:0];
      2'd1:    w_byte = w_sram_rdata[15:8];
      2'd2:    w_byte = w_sram_rdata[23:16];
      default: w_byte = w_sram_rdata[31:24];
    endcase
    w_half = r_addr[1] ? w_sram_rdata[31:16] : w_sram_rdata[15:0];
    case (r_funct3)
      F3_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      F3_LH:   w_load = {{16{w_half[15]}}, w_half};
      F3_LW:   w_load = w_sram_rdata;
      F3_LBU:  w_load = {24'h0, w_byte};
      F3_LHU:  w_load = {16'h0, w_half};
      default: w_load = 32'h0;
    endcase
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_err   = w_rsp_valid & w_err;
  assign bus.rsp_rdata = (w_rsp_valid && !r_we && !w_err) ? w_load : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Scoreboard bench for dmem_responder against a byte-addressed
//             little-endian memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk;
  logic reset_n;
  dmem_responder_if bus ();

  dmem_responder #(.DEPTH_WORDS(DEPTH)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t        exp_q[$];
  int          acc_q[$];
  logic [7:0]  mem [int unsigned];
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          hold_cycles = 0;
  bit          rand_bp = 0;
  int          stall_run = 0;
  int          last_stall = 0;
  bit          prev_rv = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: byte memory, size 1/2/4 from funct3[1:0], little endian.
  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    bit legal;
    int n;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n     = 1 << f3[1:0];
    err   = !legal || ((addr % n) != 0) || ((addr >> 2) >= 32'(DEPTH));
    rd    = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mem[addr + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < n; i++) rd = rd | ({24'h0, mem[addr + i]} << (8*i));
        if (!f3[2] && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
      end
    end
  endfunction

  // Drive one request (aligned at posedge+1) and queue its expected response.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit use_c = 0,
                       input logic [31:0] c_rd = 32'h0, input logic c_err = 1'b0);
    exp_t e;
    logic [31:0] mrd;
    logic merr;
    int guard;
    model(we, f3, addr, wd, mrd, merr);
    e.rd  = use_c ? c_rd : mrd;
    e.err = use_c ? c_err : merr;
    exp_q.push_back(e);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    guard = 0;
    while (!bus.req_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      chk("accept_timeout", 32'd1, 32'd0);
      void'(exp_q.pop_back());
    end else begin
      @(posedge clk); #1;
    end
    // Scramble the now-ignored request fields.
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() != 0 || !bus.req_ready) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  // Response acceptor: optional forced stall, optional random backpressure.
  initial begin
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (hold_cycles > 0 && bus.rsp_valid) begin
        bus.rsp_ready = 1'b0;
        hold_cycles--;
      end else begin
        bus.rsp_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: latency, stability while stalled, in-order scoreboard compare.
  initial begin
    exp_t e;
    int a;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        acc_q.delete();
        prev_rv   = 0;
        stall_run = 0;
      end else begin
        if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
        if (bus.rsp_valid && !prev_rv) begin
          if (acc_q.size() == 0) chk("latency_no_accept", 32'd1, 32'd0);
          else begin
            a = acc_q.pop_front();
            chk("latency", 32'(cyc - a), 32'd2);
          end
        end
        if (bus.rsp_valid) begin
          chk("req_ready_in_resp", {31'h0, bus.req_ready}, 32'd0);
          if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
          else begin
            e = exp_q[0];
            chk("rsp_rdata", bus.rsp_rdata, e.rd);
            chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
            if (bus.rsp_ready) begin
              void'(exp_q.pop_front());
              last_stall = stall_run;
              stall_run  = 0;
            end else begin
              stall_run++;
            end
          end
        end
        prev_rv = bus.rsp_valid;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_err", {31'h0, bus.rsp_err}, 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset_req_ready", {31'h0, bus.req_ready}, 32'd1);

    // Known contents for words 0..63; word 8 (0x20) chosen distinct from 0xA5A5A5A5.
    for (int w = 0; w < 64; w++)
      issue(1'b1, 3'd2, 32'(w * 4), (w == 8) ? 32'h0BAD_F00D : $urandom);

    // Directed sequence with literal expected values.
    issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1, 32'h0, 1'b0);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 3'd0, 32'h13, 32'h0, 1, 32'hFFFF_FFDE, 1'b0);
    issue(1'b0, 3'd4, 32'h13, 32'h0, 1, 32'h0000_00DE, 1'b0);
    issue(1'b0, 3'd1, 32'h12, 32'h0, 1, 32'hFFFF_DEAD, 1'b0);
    issue(1'b0, 3'd5, 32'h10, 32'h0, 1, 32'h0000_BEEF, 1'b0);
    issue(1'b1, 3'd0, 32'h11, 32'h55, 1, 32'h0, 1'b0);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1, 32'hDEAD_55EF, 1'b0);
    issue(1'b1, 3'd1, 32'h12, 32'h1234, 1, 32'h0, 1'b0);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1, 32'h1234_55EF, 1'b0);
    issue(1'b0, 3'd2, 32'h11, 32'h0, 1, 32'h0, 1'b1);
    issue(1'b1, 3'd1, 32'h13, 32'hFFFF_FFFF, 1, 32'h0, 1'b1);
    issue(1'b0, 3'd2, 32'(4 * DEPTH), 32'h0, 1, 32'h0, 1'b1);
    issue(1'b1, 3'd4, 32'h10, 32'hFFFF_FFFF, 1, 32'h0, 1'b1);
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1, 32'h1234_55EF, 1'b0);

    // Five-cycle response stall.
    wait_drain();
    hold_cycles = 5;
    issue(1'b0, 3'd2, 32'h10, 32'h0, 1, 32'h1234_55EF, 1'b0);
    wait_drain();
    chk("stall_cycles", 32'(last_stall), 32'd5);

    // Reset while a store sits in ACCESS: no response, no commit.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("abort_in_access", {31'h0, bus.req_ready}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    chk("abort_rsp_err", {31'h0, bus.rsp_err}, 32'd0);
    chk("abort_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("abort_req_ready", {31'h0, bus.req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    issue(1'b0, 3'd2, 32'h20, 32'h0);

    // Randomised traffic with backpressure.
    rand_bp = 1;
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 9))
        0:       addr = 32'h1000 + $urandom_range(0, 64);
        1:       addr = $urandom;
        default: addr = $urandom_range(0, 255);
      endcase
      issue(1'($urandom), 3'($urandom_range(0, 7)), addr, $urandom);
    end
    wait_drain();
    rand_bp = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the backing array (4 KiB).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  load/store request present.
REQ-005 SHALL have port req_ready  output  1  responder can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I access size/sign code.
REQ-008 SHALL have port req_addr  input  32  byte address (ALU result of the core).
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned (rs2 value).
REQ-010 SHALL have port rsp_valid  output  1  response present.
REQ-011 SHALL have port rsp_ready  input  1  requester accepts response.
REQ-012 SHALL have port rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  access fault (misaligned, out of range, illegal funct3).

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-015 IDLE: req_ready=1; req_valid=1 latches we/funct3/addr/wdata, next state ACCESS.
REQ-016 ACCESS: req_ready=0; performs the array read or byte-enabled write exactly once; next state RESP.
REQ-017 RESP: rsp_valid=1, rsp_rdata/rsp_err stable; rsp_ready=1 returns to IDLE; rsp_ready=0 holds RESP indefinitely.
REQ-018 Latency: rsp_valid SHALL rise exactly 2 cycles after the accepting edge; a new request SHALL be accepted no earlier than the cycle after the response handshake.
REQ-019 Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal store funct3: 000 SB, 001 SH, 010 SW; all others SHALL set rsp_err.
REQ-020 Misaligned (halfword with addr[0]=1, word with addr[1:0]!=0) SHALL set rsp_err.
REQ-021 addr[31:2] >= DEPTH_WORDS SHALL set rsp_err.
REQ-022 Any errored request SHALL not modify the array and SHALL return rsp_rdata=0.
REQ-023 Stores SHALL write only selected bytes: SB lane addr[1:0], SH lanes addr[1]*2..+1, SW all four; data taken from req_wdata low bits replicated to the lane.
REQ-024 Loads SHALL select the byte/halfword at addr[1:0] and sign-extend (LB, LH) or zero-extend (LBU, LHU).
REQ-025 Stores SHALL respond with rsp_err=0 and rsp_rdata=0 when legal.
REQ-026 Inputs other than req_valid SHALL be ignored outside the IDLE accepting cycle.

Reset
REQ-027 reset_n low SHALL asynchronously force state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, latched request cleared; req_ready=1 once reset deasserts.
REQ-028 Reset mid-operation SHALL abort the pending response; a store in ACCESS at the asserting edge SHALL not be committed.
REQ-029 Array contents SHALL not be cleared by reset.

Structure
REQ-030 Shared package dmem_pkg SHALL hold the funct3 constants (LB..LHU, SB..SW) and the state enum type.
REQ-031 Backing storage SHALL be a sub-module dmem_sram: synchronous, 32-bit word, 4-bit byte enable, one read-or-write port.
REQ-032 Alignment/range/funct3 checks and load extension SHALL be combinational logic within dmem_responder.

Verification
REQ-033 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid 2 cycles after each accept.
REQ-034 After REQ-033: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-035 SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF; SH 0x12 data 0x1234 then LW 0x10 -> 0x123455EF.
REQ-036 LW 0x11, SH 0x13, LW addr 4*DEPTH_WORDS, store funct3 100 -> each rsp_err 1, rsp_rdata 0; subsequent LW 0x10 unchanged 0x123455EF.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready 0 throughout; response consumed on first rsp_ready=1.
REQ-038 Assert reset_n=0 during ACCESS of SW 0x20 data 0xA5A5A5A5 -> outputs cleared immediately, no response; LW 0x20 after reset does not return 0xA5A5A5A5.
